sw_debounce_capture: RTL and testbench

Input-side companion to the switch-to-7-segment display path: samples the four raw active-low FPGA switch pins, synchronizes and debounces them, and presents clean active-high `SW_0..SW_3` levels plus a 4-bit change-event stream with a valid/ready handshake. It sits between the board pins and any logic (decoder, mux, logger) that must see stable switch values or react once per settled change.

---
 rtl/sw_debounce_capture.sv | 167 ++++++++++++++++
 tb/tb_sw_debounce_capture.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sw_debounce_capture.sv
// sw_debounce_capture: synchronizes and debounces four raw active-low switch
// pins, drives clean active-high switch levels and emits one change event per
// settled switch change over a valid/ready handshake.
//
// Optional feature macro: SW_EVENT_CNT_EN (adds EVT_CNT, a wrapping count of
// accepted events).
//
// Ports:
//   FPGA_GlobalClock         clock, rising edge
//   FPGA_RESET_N             synchronous active-low reset
//   FPGA_INPUT_PIN_0..3      raw asynchronous switch pins, active-low
//   SW_0..SW_3               debounced active-high switch levels
//   NIB_DATA[3:0]            switch nibble {SW_3..SW_0} captured at the event
//   NIB_VALID / NIB_READY    change-event handshake
//   OVERRUN / OVERRUN_CLR    sticky overwrite flag and its clear
//   EVT_CNT[7:0]             accepted-event count (SW_EVENT_CNT_EN only)
module sw_debounce_capture #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned CNT_W           = 16
) (
  input  logic       FPGA_GlobalClock,
  input  logic       FPGA_RESET_N,
  input  logic       FPGA_INPUT_PIN_0,
  input  logic       FPGA_INPUT_PIN_1,
  input  logic       FPGA_INPUT_PIN_2,
  input  logic       FPGA_INPUT_PIN_3,
  output logic       SW_0,
  output logic       SW_1,
  output logic       SW_2,
  output logic       SW_3,
  output logic [3:0] NIB_DATA,
  output logic       NIB_VALID,
  input  logic       NIB_READY,
  output logic       OVERRUN,
  input  logic       OVERRUN_CLR
`ifdef SW_EVENT_CNT_EN
  ,
  output logic [7:0] EVT_CNT
`endif
);

  localparam int unsigned NIB_W = 4;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {
    ST_STABLE   = 1'b0,
    ST_SETTLING = 1'b1
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [NIB_W-1:0]   pins;
  logic [NIB_W-1:0]   meta;
  logic [NIB_W-1:0]   sync_n;
  logic [NIB_W-1:0]   sync;
  logic [NIB_W-1:0]   cand;
  logic [NIB_W-1:0]   cand_nxt;
  logic [NIB_W-1:0]   stable;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_nxt;
  logic               commit_c;
  logic               event_c;
  logic               xfer_c;

  assign pins = {FPGA_INPUT_PIN_3, FPGA_INPUT_PIN_2, FPGA_INPUT_PIN_1, FPGA_INPUT_PIN_0};
  assign sync = ~sync_n;

  // Two-flop synchronizer; idles high so a released switch reads as off.
  always_ff @(posedge FPGA_GlobalClock) begin
    if (!FPGA_RESET_N) begin
      meta   <= {NIB_W{1'b1}};
      sync_n <= {NIB_W{1'b1}};
    end else begin
      meta   <= pins;
      sync_n <= meta;
    end
  end

  // Debounce state, candidate and settle counter.
  always_ff @(posedge FPGA_GlobalClock) begin
    if (!FPGA_RESET_N) begin
      state <= ST_STABLE;
      cand  <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cand  <= cand_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state: any movement of sync restarts the settle window.
  always_comb begin
    state_nxt = state;
    cand_nxt  = cand;
    cnt_nxt   = cnt;
    commit_c  = 1'b0;
    case (state)
      ST_STABLE: begin
        if (sync != cand) begin
          cand_nxt  = sync;
          cnt_nxt   = '0;
          state_nxt = ST_SETTLING;
        end
      end
      ST_SETTLING: begin
        if (sync != cand) begin
          cand_nxt = sync;
          cnt_nxt  = '0;
        end else if (cnt == CNT_LAST) begin
          commit_c  = 1'b1;
          state_nxt = ST_STABLE;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: state_nxt = ST_STABLE;
    endcase
  end

  // A commit that returns to the current stable value is silent.
  assign event_c = commit_c && (cand != stable);
  assign xfer_c  = NIB_VALID && NIB_READY;

  // Committed levels and event handshake; a new event on a transfer edge
  // replaces the accepted one without flagging an overrun.
  always_ff @(posedge FPGA_GlobalClock) begin
    if (!FPGA_RESET_N) begin
      stable    <= '0;
      NIB_DATA  <= '0;
      NIB_VALID <= 1'b0;
      OVERRUN   <= 1'b0;
    end else begin
      if (commit_c) begin
        stable <= cand;
      end
      if (event_c) begin
        NIB_DATA  <= cand;
        NIB_VALID <= 1'b1;
      end else if (xfer_c) begin
        NIB_VALID <= 1'b0;
      end
      if (event_c && NIB_VALID && !NIB_READY) begin
        OVERRUN <= 1'b1;
      end else if (OVERRUN_CLR) begin
        OVERRUN <= 1'b0;
      end
    end
  end

  assign SW_0 = stable[0];
  assign SW_1 = stable[1];
  assign SW_2 = stable[2];
  assign SW_3 = stable[3];

`ifdef SW_EVENT_CNT_EN
  // Accepted-event counter, wraps naturally at 8 bits.
  always_ff @(posedge FPGA_GlobalClock) begin
    if (!FPGA_RESET_N) begin
      EVT_CNT <= '0;
    end else if (xfer_c) begin
      EVT_CNT <= EVT_CNT + 8'(1);
    end
  end
`endif

endmodule

// File: tb/tb_sw_debounce_capture.sv
// tb_sw_debounce_capture: table vectors, hand-written corner sequences and a
// randomized run, all checked against a run-length reference model.
module tb_sw_debounce_capture;

  localparam int unsigned DB = 4;

  logic       clk;
  logic       rst_n;
  logic [3:0] pins_drv;
  logic       rdy;
  logic       clr;
  logic       sw0, sw1, sw2, sw3;
  logic [3:0] nib_data;
  logic       nib_valid;
  logic       overrun;
  logic [3:0] sw_vec;
`ifdef SW_EVENT_CNT_EN
  logic [7:0] evt_cnt;
`endif

  assign sw_vec = {sw3, sw2, sw1, sw0};

  sw_debounce_capture #(.DEBOUNCE_CYCLES(DB), .CNT_W(16)) dut (
    .FPGA_GlobalClock (clk),
    .FPGA_RESET_N     (rst_n),
    .FPGA_INPUT_PIN_0 (pins_drv[0]),
    .FPGA_INPUT_PIN_1 (pins_drv[1]),
    .FPGA_INPUT_PIN_2 (pins_drv[2]),
    .FPGA_INPUT_PIN_3 (pins_drv[3]),
    .SW_0             (sw0),
    .SW_1             (sw1),
    .SW_2             (sw2),
    .SW_3             (sw3),
    .NIB_DATA         (nib_data),
    .NIB_VALID        (nib_valid),
    .NIB_READY        (rdy),
    .OVERRUN          (overrun),
    .OVERRUN_CLR      (clr)
`ifdef SW_EVENT_CNT_EN
    ,
    .EVT_CNT          (evt_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a switch value is accepted once the synchronized input
  // (pins seen two edges late, inverted) has held it for DB+1 edges in a row.
  logic [3:0] m_p1, m_p2;
  logic [3:0] m_run_val;
  int         m_run_len;
  logic [3:0] m_stable, m_data;
  logic       m_valid, m_ovr, model_ok;
  logic [7:0] m_cnt;

  task automatic model_step();
    logic [3:0] s;
    logic commit, evt, xfer;
    if (!rst_n) begin
      m_p1 = 4'hF; m_p2 = 4'hF;
      m_run_val = 4'h0; m_run_len = DB + 2;
      m_stable = 4'h0; m_data = 4'h0; m_valid = 1'b0; m_ovr = 1'b0;
      m_cnt = 8'h0; model_ok = 1'b1;
      return;
    end
    s = ~m_p2;
    m_p2 = m_p1;
    m_p1 = pins_drv;
    if (s != m_run_val) begin
      m_run_val = s;
      m_run_len = 1;
    end else if (m_run_len < DB + 2) begin
      m_run_len++;
    end
    commit = (m_run_len == DB + 1);
    evt    = commit && (m_run_val != m_stable);
    xfer   = m_valid && rdy;
    if (xfer) m_cnt = m_cnt + 8'(1);
    if (commit) m_stable = m_run_val;
    if (evt) begin
      if (m_valid && !rdy) m_ovr = 1'b1;
      else if (clr) m_ovr = 1'b0;
      m_data  = m_run_val;
      m_valid = 1'b1;
    end else begin
      if (xfer) m_valid = 1'b0;
      if (clr) m_ovr = 1'b0;
    end
  endtask

  int         seen_valid = 0;
  logic [3:0] last_data  = 4'h0;

  // One clock: update model on the edge, compare against it half a cycle later.
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    if (model_ok) begin
      chk("model_sw", 8'(sw_vec), 8'(m_stable));
      chk("model_valid", 8'(nib_valid), 8'(m_valid));
      if (m_valid) chk("model_data", 8'(nib_data), 8'(m_data));
      chk("model_ovr", 8'(overrun), 8'(m_ovr));
`ifdef SW_EVENT_CNT_EN
      chk("model_evt_cnt", evt_cnt, m_cnt);
`endif
    end
    if (nib_valid === 1'b1) begin
      seen_valid++;
      last_data = nib_data;
    end
  endtask

  typedef struct {
    logic [3:0] pins;
    logic       rdy;
    logic       clr;
    logic       rst_n;
    int         n;
    logic [3:0] sw;
    logic       v;
    logic [3:0] d;
    logic       ovr;
  } vec_t;

  vec_t tbl[12];

  initial begin
    model_ok = 1'b0;
    rst_n = 1'b0; pins_drv = 4'hF; rdy = 1'b0; clr = 1'b0;

    //            pins  rdy   clr   rst   n   sw    v     d     ovr
    tbl[0]  = '{4'hF, 1'b0, 1'b0, 1'b0, 2,  4'h0, 1'b0, 4'h0, 1'b0};
    tbl[1]  = '{4'hF, 1'b0, 1'b0, 1'b1, 50, 4'h0, 1'b0, 4'h0, 1'b0};
    tbl[2]  = '{4'hE, 1'b0, 1'b0, 1'b1, 6,  4'h0, 1'b0, 4'h0, 1'b0};
    tbl[3]  = '{4'hE, 1'b0, 1'b0, 1'b1, 1,  4'h1, 1'b1, 4'h1, 1'b0};
    tbl[4]  = '{4'hE, 1'b1, 1'b0, 1'b1, 1,  4'h1, 1'b0, 4'h1, 1'b0};
    tbl[5]  = '{4'hC, 1'b0, 1'b0, 1'b1, 7,  4'h3, 1'b1, 4'h3, 1'b0};
    tbl[6]  = '{4'hC, 1'b0, 1'b0, 1'b1, 20, 4'h3, 1'b1, 4'h3, 1'b0};
    tbl[7]  = '{4'h8, 1'b0, 1'b0, 1'b1, 7,  4'h7, 1'b1, 4'h7, 1'b1};
    tbl[8]  = '{4'h8, 1'b0, 1'b1, 1'b1, 1,  4'h7, 1'b1, 4'h7, 1'b0};
    tbl[9]  = '{4'h8, 1'b1, 1'b0, 1'b1, 1,  4'h7, 1'b0, 4'h7, 1'b0};
    tbl[10] = '{4'hF, 1'b1, 1'b0, 1'b1, 7,  4'h0, 1'b1, 4'h0, 1'b0};
    tbl[11] = '{4'hF, 1'b1, 1'b0, 1'b1, 1,  4'h0, 1'b0, 4'h0, 1'b0};

    @(negedge clk);
    for (int i = 0; i < 12; i++) begin
      pins_drv = tbl[i].pins; rdy = tbl[i].rdy; clr = tbl[i].clr; rst_n = tbl[i].rst_n;
      repeat (tbl[i].n) tick();
      chk($sformatf("vec%0d_sw", i), 8'(sw_vec), 8'(tbl[i].sw));
      chk($sformatf("vec%0d_valid", i), 8'(nib_valid), 8'(tbl[i].v));
      chk($sformatf("vec%0d_data", i), 8'(nib_data), 8'(tbl[i].d));
      chk($sformatf("vec%0d_ovr", i), 8'(overrun), 8'(tbl[i].ovr));
    end

    // Bouncing pin 2 that returns high: silent.
    rdy = 1'b1; clr = 1'b0; seen_valid = 0;
    for (int i = 0; i < 10; i++) begin
      pins_drv = i[0] ? 4'hF : 4'hB;
      repeat (2) tick();
    end
    pins_drv = 4'hF;
    repeat (20) tick();
    chk("bounce_back_events", 8'(seen_valid), 8'd0);
    chk("bounce_back_sw2", 8'(sw2), 8'd0);

    // Bouncing pin 2 that settles low: exactly one event.
    seen_valid = 0;
    for (int i = 0; i < 10; i++) begin
      pins_drv = i[0] ? 4'hF : 4'hB;
      repeat (2) tick();
    end
    pins_drv = 4'hB;
    repeat (20) tick();
    chk("bounce_low_events", 8'(seen_valid), 8'd1);
    chk("bounce_low_data", 8'(last_data), 8'h4);
    pins_drv = 4'hF;
    repeat (20) tick();

    // Reset two cycles into settling with pin 3 low.
    seen_valid = 0;
    pins_drv = 4'h7;
    repeat (5) tick();
    rst_n = 1'b0;
    tick();
    chk("midreset_valid", 8'(nib_valid), 8'd0);
    chk("midreset_sw", 8'(sw_vec), 8'd0);
    chk("midreset_events", 8'(seen_valid), 8'd0);
    rst_n = 1'b1;
    begin
      int edges;
      edges = 0;
      while (nib_valid !== 1'b1 && edges < 30) begin
        tick();
        edges++;
      end
      chk("postreset_latency", 8'(edges), 8'(DB + 3));
      chk("postreset_data", 8'(nib_data), 8'h8);
    end

    // Randomized traffic against the model.
    begin
      int hold;
      hold = 0;
      for (int i = 0; i < 3000; i++) begin
        if (hold == 0) begin
          if ($urandom_range(0, 1) == 0) pins_drv = 4'($urandom_range(0, 15));
          else pins_drv = pins_drv ^ (4'h1 << $urandom_range(0, 3));
          hold = (DB + 2) * $urandom_range(0, 2) + $urandom_range(1, 4);
        end
        hold--;
        rdy   = ($urandom_range(0, 2) == 0);
        clr   = ($urandom_range(0, 7) == 0);
        rst_n = ($urandom_range(0, 399) != 0);
        tick();
      end
    end

`ifdef SW_EVENT_CNT_EN
    // 257 accepted events wrap the counter to 1.
    rst_n = 1'b0; rdy = 1'b1; clr = 1'b0; pins_drv = 4'hF;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 257; i++) begin
      pins_drv = i[0] ? 4'hF : 4'hE;
      repeat (DB + 4) tick();
    end
    repeat (4) tick();
    chk("evt_cnt_wrap", evt_cnt, 8'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
